muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_datapath.sv | 68 ++++++
 rtl/muldiv_sequencer.sv | 67 ++++++
 tb/tb_muldiv_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared funct3 codes, FSM state encoding and default width for the RV32M unit
package muldiv_pkg;
  localparam int DEF_XLEN = 32;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: magnitude shift-add multiplier / restoring divider with sign fix-up
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_fix,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  output logic            o_special,
  output logic [XLEN-1:0] o_result
);
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b, r_result;
  logic [2:0]        r_f3;
  logic              r_neg;
  logic              w_sa, w_sb, w_div0, w_ovf, w_neg_ld, w_ge;
  logic [XLEN-1:0]   w_ma, w_mb, w_spec_val, w_dsel, w_fix;
  logic [XLEN:0]     w_add, w_rsh, w_diff;
  logic [2*XLEN-1:0] w_mul_nx, w_div_nx, w_prod;
  assign w_sa = i_op_a[XLEN-1] & (i_funct3 == F3_MULH || i_funct3 == F3_MULHSU ||
                                  i_funct3 == F3_DIV || i_funct3 == F3_REM);
  assign w_sb = i_op_b[XLEN-1] & (i_funct3 == F3_MULH || i_funct3 == F3_DIV || i_funct3 == F3_REM);
  assign w_ma = w_sa ? -i_op_a : i_op_a;
  assign w_mb = w_sb ? -i_op_b : i_op_b;
  assign w_neg_ld = i_funct3[2] & i_funct3[1] ? w_sa : w_sa ^ w_sb;
  assign w_div0 = i_op_b == '0;
  assign w_ovf = (i_funct3 == F3_DIV || i_funct3 == F3_REM) &&
                 i_op_a == {1'b1, {(XLEN-1){1'b0}}} && &i_op_b;
  assign o_special = i_funct3[2] & (w_div0 | w_ovf);
  assign w_spec_val = i_funct3[1] ? (w_div0 ? i_op_a : '0) : (w_div0 ? '1 : {1'b1, {(XLEN-1){1'b0}}});
  // multiply: multiplier sits in the low half and shifts out as the product shifts in
  assign w_add = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nx = {w_add, r_acc[XLEN-1:1]};
  // divide: shifted remainder needs XLEN+1 bits; bit XLEN of the difference is the borrow
  assign w_rsh = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff = w_rsh - {1'b0, r_b};
  assign w_ge = ~w_diff[XLEN];
  assign w_div_nx = {w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_dsel = r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
  assign w_fix = r_f3[2] ? (r_neg ? -w_dsel : w_dsel)
                         : (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  assign o_result = r_result;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      if (i_load) begin
        r_acc <= {{XLEN{1'b0}}, i_funct3[2] ? w_ma : w_mb};
        r_b   <= i_funct3[2] ? w_mb : w_ma;
        r_f3  <= i_funct3;
        r_neg <= w_neg_ld;
        if (o_special) r_result <= w_spec_val;
      end
      if (i_step) r_acc <= r_f3[2] ? w_div_nx : w_mul_nx;
      if (i_fix) r_result <= w_fix;
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M iterative multiply/divide FSM driving muldiv_datapath,
// stalling the pipeline until a one-cycle done pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             w_load, w_step, w_fix, w_special;
  assign w_load = r_state == S_IDLE && start && !flush;
  assign w_step = r_state == S_CALC && !flush;
  assign w_fix  = r_state == S_FIX && !flush;
  assign stall  = w_load || r_state == S_CALC || r_state == S_FIX;
  assign busy   = r_state != S_IDLE;
  assign done   = r_done;
  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_fix     (w_fix),
    .i_funct3  (funct3),
    .i_op_a    (op_a),
    .i_op_b    (op_b),
    .o_special (w_special),
    .o_result  (result)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: if (w_load) begin
          r_state <= w_special ? S_DONE : S_CALC;
          r_cnt   <= w_special ? '0 : CNT_W'(XLEN);
          r_done  <= w_special;
        end
        S_CALC: begin
          r_cnt   <= flush ? '0 : r_cnt - 1'b1;
          r_state <= flush ? S_IDLE : (r_cnt == CNT_W'(1) ? S_FIX : S_CALC);
        end
        S_FIX: begin
          r_state <= flush ? S_IDLE : S_DONE;
          r_done  <= !flush;
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed-vector bench for the RV32M multiply/divide sequencer
module tb_muldiv_sequencer;
  import muldiv_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, stall, done;
  logic [31:0] result;
  int n_pass = 0, n_tot = 0;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tot++; if ({busy, stall, done} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {busy, stall, done}); else n_pass++;
    n_tot++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", result); else n_pass++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat);
    int cyc = 0, st = 0;
    @(posedge clk); #1;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1;
    while (!done && cyc <= 60) begin
      if (stall) st++;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    n_tot++; if (cyc !== exp_lat) $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_lat); else n_pass++;
    n_tot++; if (st !== exp_lat) $display("FAIL %s stall_cycles: got %0d want %0d", nm, st, exp_lat); else n_pass++;
    n_tot++; if (result !== exp_r) $display("FAIL %s result: got %h want %h", nm, result, exp_r); else n_pass++;
    n_tot++; if (stall !== 1'b0) $display("FAIL %s stall_at_done: got %b want 0", nm, stall); else n_pass++;
    @(posedge clk); #1;
    n_tot++; if ({done, busy} !== 2'b00) $display("FAIL %s done_pulse: got %b want 00", nm, {done, busy}); else n_pass++;
  endtask

  task automatic test_mul();
    run_op("mul_7_m3", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulhu_ff", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulh_ff", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
  endtask

  task automatic test_div();
    run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 34);
  endtask

  task automatic test_special();
    run_op("divu_by0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0", F3_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
  endtask

  task automatic test_flush();
    int cyc = 0;
    logic seen = 1'b0;
    run_op("mul_pre", F3_MUL, 32'd6, 32'd7, 32'd42, 34);
    @(posedge clk); #1;
    funct3 = F3_MUL; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      start = 1'b0; cyc++; seen |= done;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen |= done;
    n_tot++; if ({busy, stall} !== 2'b00) $display("FAIL flush_idle: got %b want 00", {busy, stall}); else n_pass++;
    n_tot++; if (seen !== 1'b0) $display("FAIL flush_no_done: got %b want 0", seen); else n_pass++;
    n_tot++; if (result !== 32'd42) $display("FAIL flush_result: got %h want 0000002a", result); else n_pass++;
    run_op("mul_after_flush", F3_MUL, 32'd3, 32'd5, 32'd15, 34);
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    #1;
    n_tot++; if (stall !== 1'b0) $display("FAIL start_flush_stall: got %b want 0", stall); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_tot++; if (busy !== 1'b0) $display("FAIL start_flush_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_start_in_done();
    int cyc = 0;
    @(posedge clk); #1;
    funct3 = F3_MUL; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc <= 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_tot++; if (done !== 1'b1) $display("FAIL sid_done: got %b want 1", done); else n_pass++;
    funct3 = F3_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tot++; if ({busy, done} !== 2'b00) $display("FAIL sid_relaunch: got %b want 00", {busy, done}); else n_pass++;
    n_tot++; if (result !== 32'd42) $display("FAIL sid_result: got %h want 0000002a", result); else n_pass++;
    @(posedge clk); #1;
    n_tot++; if (busy !== 1'b0) $display("FAIL sid_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    funct3 = F3_MUL; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    n_tot++; if ({busy, stall} !== 2'b11) $display("FAIL arst_pre: got %b want 11", {busy, stall}); else n_pass++;
    rst = 1'b1;
    #1;
    n_tot++; if ({busy, stall, done} !== 3'b000) $display("FAIL arst_ctrl: got %b want 000", {busy, stall, done}); else n_pass++;
    n_tot++; if (result !== 32'h0) $display("FAIL arst_result: got %h want 00000000", result); else n_pass++;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tot++; if ({busy, done} !== 2'b00) $display("FAIL arst_after: got %b want 00", {busy, done}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_start_in_done();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
